pwm_fade_sequencer: RTL
=======================

Name: pwm_fade_sequencer

Overview:
- Controller that sequences the duty-cycle input of the team's 4-bit PWM generator to produce a fade ("breathing") profile.
- Profile: ramp up to a latched maximum, hold, ramp down to zero, hold low.
- duty_o connects directly to the generator's duty input. A fixed step period paces every duty change.
- Graceful stop: always ramps back down to zero before going idle.

Parameters:
- DUTY_W, 4, width of duty value; matches the PWM generator duty input.
- STEP_CYCLES, 16, clock cycles per step tick; legal range 2..65535.
- HOLD_STEPS, 4, number of ticks spent in each hold state; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- start_i  input  1  level-sampled request to begin a fade; acted on only in IDLE
- stop_i  input  1  request graceful stop; ignored in IDLE
- max_duty_i  input  DUTY_W  peak duty, latched at start acceptance
- duty_o  output  DUTY_W  duty value to PWM generator (registered)
- busy_o  output  1  high whenever state != IDLE
- done_o  output  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; duty_o=0, busy_o=0, done_o=0.
  - Tick counter, hold counter, max_q and stop_pend all cleared.
  - Mid-run reset aborts immediately; duty_o drops to 0 without ramping.
- Tick generation:
  - Tick counter runs only when state != IDLE; it is cleared on start acceptance.
  - tick=1 on the cycle where counter==STEP_CYCLES-1; the counter wraps to 0 on that cycle.
  - All duty changes and state changes except start/stop happen on tick cycles. Results are visible the next cycle.
- IDLE:
  - start_i=1: latch max_q<=max_duty_i, go to RAMP_UP; busy_o=1 from the next cycle.
  - start_i and stop_i asserted together in IDLE: start is accepted, stop is discarded.
- RAMP_UP, on tick:
  - duty_o==max_q: go to HOLD_HIGH, clear hold counter.
  - Otherwise duty_o+1.
  - max_q==0 therefore spends exactly 1 tick in RAMP_UP.
- HOLD_HIGH, on tick:
  - hold_cnt==HOLD_STEPS-1: go to RAMP_DOWN.
  - Otherwise hold_cnt+1.
- RAMP_DOWN, on tick:
  - duty_o==0: go to HOLD_LOW, clear hold counter.
  - Otherwise duty_o-1.
- HOLD_LOW, on tick:
  - On the last hold tick (hold_cnt==HOLD_STEPS-1), go to IDLE.
  - done_o=1 during the first cycle in IDLE; clear stop_pend.
- Stop handling:
  - stop_i=1 in RAMP_UP or HOLD_HIGH: go to RAMP_DOWN on the next clock, with or without a tick. duty_o is held; the tick counter is not cleared.
  - Stop takes priority over a coincident tick.
  - stop_i in RAMP_DOWN or HOLD_LOW: only sets stop_pend.
- Start while busy: ignored; max_duty_i changes mid-run are ignored.
- Arithmetic: duty_o never exceeds max_q and never underflows below 0. No wrap-around is possible by construction.
- One-shot length (no stop), with M=max_q, S=STEP_CYCLES, H=HOLD_STEPS: (2M+2+2H)*S cycles from the first RAMP_UP cycle to the first IDLE cycle.

Optional Feature:
- Macro: PWM_FADE_LOOP_EN.
- Defined: on the last HOLD_LOW tick with stop_pend=0, go to RAMP_UP instead of IDLE, re-latching max_q<=max_duty_i. No done_o pulse is issued. With stop_pend=1, go to IDLE with done_o.
- Undefined: one-shot behaviour as above; stop_pend only tracks stop requests.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - state enum typedef: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW (3-bit encoding);
  - DUTY_W default constant.
- Sub-module pwm_step_tick holds the prescaler: parameter STEP_CYCLES; inputs en and clr; output tick. It is reusable for other rate-paced controllers.

Test Plan:
- Reset held, start_i=1 -> duty_o=0, busy_o=0, done_o=0 throughout. Release rst -> start is accepted next edge.
- One-shot, S=16, H=4, max_duty_i=7 -> duty_o increments 0..7 every 16 cycles, then holds 7 for 4 ticks, then decrements to 0. done_o pulses exactly once, 384 cycles after the first RAMP_UP cycle.
- max_duty_i=0 -> duty_o stays 0. done_o after (2+8)*16=160 cycles.
- Stop at duty_o=3 during RAMP_UP, coincident with a tick -> next cycle state RAMP_DOWN, duty_o still 3. Then 3,2,1,0, HOLD_LOW, done_o.
- start_i pulsed mid-run with max_duty_i=15 -> ignored; peak remains 7. Async reset asserted mid-HOLD_HIGH -> duty_o=0 immediately, no done_o.
- PWM_FADE_LOOP_EN defined, max 2, change max_duty_i to 5 during the first cycle -> second cycle peaks at 5, no done_o. stop_i during the second HOLD_HIGH -> ramp down, single done_o, busy_o=0.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types for PWM duty controllers.
// Holds the fade state encoding and default duty width.
package pwm_ctrl_pkg;

    localparam int DUTY_W_DFLT = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } fade_state_e;

endpackage

// File: rtl/pwm_step_tick.sv
// Step-rate prescaler: one-cycle tick every STEP_CYCLES enabled cycles.
// clr restarts the period; counter holds while en is low.
module pwm_step_tick #(
    parameter int STEP_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    // Period counter, wraps to zero on the tick cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Breathing-profile sequencer driving a PWM generator duty input.
// Define PWM_FADE_LOOP_EN to repeat the profile until stopped.
module pwm_fade_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W      = DUTY_W_DFLT,
    parameter int STEP_CYCLES = 16,
    parameter int HOLD_STEPS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [DUTY_W-1:0] max_duty_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              busy_o,
    output logic              done_o
);

`ifdef PWM_FADE_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_STEPS - 1);

    fade_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] max_q, max_d;
    logic [7:0]        hold_q, hold_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;
    logic              tick;
    logic              tick_clr;

    pwm_step_tick #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state_q != IDLE),
        .clr (tick_clr),
        .tick(tick)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            max_q   <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            max_q   <= max_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update; stop wins over a same-cycle tick
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        max_d    = max_q;
        hold_d   = hold_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        tick_clr = 1'b0;
        if (state_q != IDLE && stop_i) pend_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    max_d    = max_duty_i;
                    duty_d   = '0;
                    tick_clr = 1'b1;
                    state_d  = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (stop_i) begin
                    state_d = RAMP_DOWN;
                end else if (tick) begin
                    if (duty_q == max_q) begin
                        state_d = HOLD_HIGH;
                        hold_d  = '0;
                    end else begin
                        duty_d = duty_q + DUTY_W'(1);
                    end
                end
            end
            HOLD_HIGH: begin
                if (stop_i) begin
                    state_d = RAMP_DOWN;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) state_d = RAMP_DOWN;
                    else hold_d = hold_q + 8'd1;
                end
            end
            RAMP_DOWN: begin
                if (tick) begin
                    if (duty_q == '0) begin
                        state_d = HOLD_LOW;
                        hold_d  = '0;
                    end else begin
                        duty_d = duty_q - DUTY_W'(1);
                    end
                end
            end
            HOLD_LOW: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        if (LOOP_EN && !pend_q) begin
                            state_d = RAMP_UP;
                            max_d   = max_duty_i;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            pend_d  = 1'b0;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign duty_o = duty_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule
